// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit: word-addressed request with byte enables,
// completed by a single-cycle acknowledge.
interface load_store_unit_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_rdata, m_ack
    );

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_rdata, m_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian MIPS-style load/store unit: one access at a time, byte/half/word formatting,
// timeout abort. Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] rt_reg,
    input  logic [5:0]  opcode,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        err,
    output logic        misaligned,
    load_store_unit_if.master mem
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_p0;
    logic [31:0]        data_p0;
    logic [5:0]         op_p0;
    logic [31:0]        load_data_q;
    logic               err_q;
    logic               mis_q;

    logic               take;
    logic               fin;
    logic               fin_err;
    logic               fin_mis;
    logic [31:0]        fin_data;
    logic               cnt_inc;
    logic               req_ok;
    logic               mis_trap;

    function automatic logic known_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (op)
            OP_SB: be = 4'b1000 >> off;
            OP_SH: be = off[1] ? 4'b0011 : 4'b1100;
            OP_SW: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] d);
        logic [31:0] w;
        case (op)
            OP_SB:   w = {4{d[7:0]}};
            OP_SH:   w = {2{d[15:0]}};
            OP_SW:   w = d;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Offset 0 is the most significant lane (big-endian byte numbering).
    function automatic logic [31:0] format_load(input logic [5:0] op, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext_s;
        logic [31:0]        res;
        case (off)
            2'd0:    b_s = rd[31:24];
            2'd1:    b_s = rd[23:16];
            2'd2:    b_s = rd[15:8];
            default: b_s = rd[7:0];
        endcase
        h_s   = off[1] ? rd[15:0] : rd[31:16];
        ext_s = 32'sd0;
        res   = 32'd0;
        case (op)
            OP_LB:  begin ext_s = b_s; res = ext_s; end
            OP_LBU: res = {24'd0, b_s};
            OP_LH:  begin ext_s = h_s; res = ext_s; end
            OP_LHU: res = {16'd0, h_s};
            OP_LW:  res = rd;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misalign(input logic [5:0] op, input logic [1:0] off);
        logic m;
        case (op)
            OP_LH, OP_LHU, OP_SH: m = off[0];
            OP_LW, OP_SW:         m = (off != 2'b00);
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

    assign mis_trap = misalign(opcode, addr[1:0]);
`else
    assign mis_trap = 1'b0;
`endif

    assign req_ok = known_op(opcode) && (mem_read ^ mem_write) && (is_store(opcode) == mem_write);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        fin_mis   = 1'b0;
        fin_data  = 32'd0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!req_ok) begin
                        state_nxt = DONE;
                        fin       = 1'b1;
                        fin_err   = 1'b1;
                    end else if (mis_trap) begin
                        state_nxt = DONE;
                        fin       = 1'b1;
                        fin_err   = 1'b1;
                        fin_mis   = 1'b1;
                    end else begin
                        state_nxt = ACCESS;
                        take      = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // An acknowledge in the final allowed cycle still completes the access.
                if (mem.m_ack) begin
                    state_nxt = DONE;
                    fin       = 1'b1;
                    fin_data  = is_store(op_p0) ? 32'd0
                                                : format_load(op_p0, addr_p0[1:0], mem.m_rdata);
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = DONE;
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture and completion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            addr_p0     <= 32'd0;
            data_p0     <= 32'd0;
            op_p0       <= 6'd0;
            load_data_q <= 32'd0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            if (take) begin
                cnt     <= '0;
                addr_p0 <= addr;
                data_p0 <= rt_reg;
                op_p0   <= opcode;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (fin) begin
                load_data_q <= fin_data;
                err_q       <= fin_err;
                mis_q       <= fin_mis;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign load_data  = load_data_q;
    assign err        = done & err_q;
    assign misaligned = done & mis_q;

    // Bus outputs are only driven while the access is outstanding.
    assign mem.m_req   = (state == ACCESS);
    assign mem.m_we    = mem.m_req & is_store(op_p0);
    assign mem.m_addr  = mem.m_req ? {addr_p0[31:2], 2'b00} : 32'd0;
    assign mem.m_be    = mem.m_req ? store_be(op_p0, addr_p0[1:0]) : 4'b0000;
    assign mem.m_wdata = mem.m_req ? store_wdata(op_p0, data_p0) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural lane model.
module tb_load_store_unit;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rt_reg = 32'd0;
    logic [5:0]  opcode = 6'd0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        busy, done, err, misaligned;
    logic [31:0] load_data;

    int tests = 0;
    int fails = 0;

    load_store_unit_if mem ();

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rt_reg(rt_reg),
        .opcode(opcode), .mem_read(mem_read), .mem_write(mem_write), .busy(busy),
        .done(done), .load_data(load_data), .err(err), .misaligned(misaligned),
        .mem(mem.master)
    );

    always #5 clk = ~clk;

    function automatic logic m_store(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic m_trap(input logic [5:0] op, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (op == LH || op == LHU || op == SH) return a % 2 != 0;
        if (op == LW || op == SW) return a % 4 != 0;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
        int off;
        off = a % 4;
        if (op == SB) return 4'b1000 >> off;
        if (op == SH) return 4'b1100 >> (2 * (off / 2));
        if (op == SW) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
        if (op == SB) return (d % 256) * 32'h01010101;
        if (op == SH) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int off;
        off = a % 4;
        if (op == LB || op == LBU) begin
            v = (rd >> (8 * (3 - off))) % 256;
            if (op == LB && v >= 128) v = v - 256;
            return v;
        end
        if (op == LH || op == LHU) begin
            v = (rd >> (16 * (1 - off / 2))) % 65536;
            if (op == LH && v >= 32768) v = v - 65536;
            return v;
        end
        return rd;
    endfunction

    task automatic do_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                             input logic [31:0] rd, input int dly, input string nm,
                             output logic [31:0] o_addr, output logic [3:0] o_be,
                             output logic [31:0] o_wdata);
        logic st, trap;
        logic [31:0] exp_ld;
        st = m_store(op);
        trap = m_trap(op, a);
        exp_ld = st ? 32'd0 : m_load(op, a, rd);
        o_addr = 32'd0; o_be = 4'd0; o_wdata = 32'd0;
        @(negedge clk);
        start = 1'b1; addr = a; rt_reg = rt; opcode = op; mem_read = !st; mem_write = st;
        @(negedge clk);
        start = 1'b0; addr = $urandom; rt_reg = $urandom;
        if (trap) begin
            tests++;
            if (mem.m_req !== 1'b0 || done !== 1'b1 || err !== 1'b1 || misaligned !== 1'b1 ||
                load_data !== 32'd0) begin
                fails++;
                $display("FAIL %s trap: req=%b done=%b err=%b mis=%b ld=%h, need 0 1 1 1 0",
                         nm, mem.m_req, done, err, misaligned, load_data);
            end
            @(negedge clk);
            return;
        end
        o_addr = mem.m_addr; o_be = mem.m_be; o_wdata = mem.m_wdata;
        tests++;
        if (mem.m_req !== 1'b1 || mem.m_we !== st || mem.m_addr !== {a[31:2], 2'b00} ||
            mem.m_be !== m_be(op, a) || (st && mem.m_wdata !== m_wdata(op, rt)) || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s req: req=%b we=%b addr=%h be=%b wd=%h busy=%b, need 1 %b %h %b %h 1",
                     nm, mem.m_req, mem.m_we, mem.m_addr, mem.m_be, mem.m_wdata, busy, st,
                     {a[31:2], 2'b00}, m_be(op, a), m_wdata(op, rt));
        end
        for (int i = 1; i < dly; i++) begin
            @(negedge clk);
            tests++;
            if (mem.m_req !== 1'b1 || done !== 1'b0 || mem.m_addr !== o_addr || mem.m_be !== o_be ||
                mem.m_wdata !== o_wdata) begin
                fails++;
                $display("FAIL %s hold%0d: req=%b done=%b addr=%h be=%b wd=%h, need 1 0 %h %b %h",
                         nm, i, mem.m_req, done, mem.m_addr, mem.m_be, mem.m_wdata,
                         o_addr, o_be, o_wdata);
            end
        end
        mem.m_ack = 1'b1; mem.m_rdata = rd;
        @(negedge clk);
        mem.m_ack = 1'b0; mem.m_rdata = $urandom;
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || misaligned !== 1'b0 || mem.m_req !== 1'b0 ||
            (!st && load_data !== exp_ld)) begin
            fails++;
            $display("FAIL %s done: done=%b err=%b mis=%b req=%b ld=%h, need 1 0 0 0 %h",
                     nm, done, err, misaligned, mem.m_req, load_data, exp_ld);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || (!st && load_data !== exp_ld)) begin
            fails++;
            $display("FAIL %s idle: done=%b busy=%b ld=%h, need 0 0 %h",
                     nm, done, busy, load_data, exp_ld);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (busy !== 0 || done !== 0 || err !== 0 || misaligned !== 0 || load_data !== 0 ||
            mem.m_req !== 0 || mem.m_we !== 0 || mem.m_addr !== 0 || mem.m_be !== 0 ||
            mem.m_wdata !== 0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b err=%b ld=%h req=%b be=%b, need all zero",
                     busy, done, err, load_data, mem.m_req, mem.m_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] oa, ow;
        logic [3:0]  ob;
        do_access(SW, 32'h10, 32'hDEADBEEF, 32'h0, 1, "sw", oa, ob, ow);
        tests++;
        if (oa !== 32'h10 || ob !== 4'b1111 || ow !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sw_const: addr=%h be=%b wd=%h, need 00000010 1111 deadbeef", oa, ob, ow);
        end
        do_access(LB, 32'h13, 32'h0, 32'h1122338F, 2, "lb", oa, ob, ow);
        tests++;
        if (load_data !== 32'hFFFFFF8F || ob !== 4'b0000) begin
            fails++;
            $display("FAIL lb_const: ld=%h be=%b, need ffffff8f 0000", load_data, ob);
        end
        do_access(LBU, 32'h13, 32'h0, 32'h1122338F, 1, "lbu", oa, ob, ow);
        tests++;
        if (load_data !== 32'h0000008F) begin
            fails++;
            $display("FAIL lbu_const: ld=%h, need 0000008f", load_data);
        end
        do_access(LH, 32'h22, 32'h0, 32'h0000F00D, 3, "lh", oa, ob, ow);
        tests++;
        if (load_data !== 32'hFFFFF00D) begin
            fails++;
            $display("FAIL lh_const: ld=%h, need fffff00d", load_data);
        end
        do_access(SH, 32'h22, 32'h1234ABCD, 32'h0, 1, "sh", oa, ob, ow);
        tests++;
        if (ob !== 4'b0011 || ow !== 32'hABCDABCD || oa !== 32'h20) begin
            fails++;
            $display("FAIL sh_const: addr=%h be=%b wd=%h, need 00000020 0011 abcdabcd", oa, ob, ow);
        end
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk);
        start = 1'b1; addr = 32'h80; opcode = LW; mem_read = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (mem.m_req === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (n !== 16 || done !== 1'b1 || err !== 1'b1 || load_data !== 32'd0) begin
            fails++;
            $display("FAIL timeout: req_cycles=%0d done=%b err=%b ld=%h, need 16 1 1 0",
                     n, done, err, load_data);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: done=%b busy=%b, need 0 0", done, busy);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] oa, ow;
        logic [3:0]  ob;
        do_access(LW, 32'h41, 32'h0, 32'hCAFEF00D, 1, "lw_41", oa, ob, ow);
`ifndef LSU_MISALIGN_TRAP_EN
        tests++;
        if (oa !== 32'h40 || load_data !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL lw_41_const: addr=%h ld=%h, need 00000040 cafef00d", oa, load_data);
        end
`endif
    endtask

    task automatic test_invalid();
        logic [5:0] ops [4] = '{LW, SW, 6'b000000, LW};
        logic       rds [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       wrs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1; addr = $urandom; opcode = ops[i]; mem_read = rds[i]; mem_write = wrs[i];
            @(negedge clk);
            start = 1'b0;
            tests++;
            if (mem.m_req !== 1'b0 || done !== 1'b1 || err !== 1'b1 || misaligned !== 1'b0 ||
                load_data !== 32'd0) begin
                fails++;
                $display("FAIL invalid%0d: req=%b done=%b err=%b mis=%b ld=%h, need 0 1 1 0 0",
                         i, mem.m_req, done, err, misaligned, load_data);
            end
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || busy !== 1'b0 || mem.m_req !== 1'b0) begin
                fails++;
                $display("FAIL invalid%0d_idle: done=%b busy=%b req=%b, need 0 0 0",
                         i, done, busy, mem.m_req);
            end
        end
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        start = 1'b1; addr = 32'h100; opcode = LW; mem_read = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        start = 1'b1; addr = 32'h200; opcode = SW; rt_reg = 32'h55; mem_read = 1'b0; mem_write = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (mem.m_addr !== 32'h100 || mem.m_we !== 1'b0 || mem.m_req !== 1'b1) begin
            fails++;
            $display("FAIL busy_ignore: addr=%h we=%b req=%b, need 00000100 0 1",
                     mem.m_addr, mem.m_we, mem.m_req);
        end
        mem.m_ack = 1'b1; mem.m_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem.m_ack = 1'b0;
        tests++;
        if (done !== 1'b1 || load_data !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL busy_done: done=%b ld=%h, need 1 0badf00d", done, load_data);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || mem.m_req !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL busy_noextra: busy=%b req=%b done=%b, need 0 0 0", busy, mem.m_req, done);
        end
    endtask

    task automatic test_reset_in_access();
        int seen;
        @(negedge clk);
        start = 1'b1; addr = 32'h300; opcode = LW; mem_read = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (mem.m_req !== 1'b0 || busy !== 1'b0 || load_data !== 32'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_abort: req=%b busy=%b ld=%h done=%b, need 0 0 0 0",
                     mem.m_req, busy, load_data, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem.m_ack = 1'b1; mem.m_rdata = 32'h12345678;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || mem.m_req !== 1'b0 || busy !== 1'b0) seen++;
        end
        mem.m_ack = 1'b0;
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_late_ack: %0d cycles with activity, need 0", seen);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        logic [31:0] oa, ow;
        logic [3:0]  ob;
        for (int i = 0; i < 40; i++) begin
            do_access(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                      $urandom_range(1, 5), $sformatf("rnd%0d", i), oa, ob, ow);
        end
    endtask

    initial begin
        mem.m_ack = 1'b0;
        mem.m_rdata = 32'd0;
        test_reset();
        test_directed();
        test_timeout();
        test_misalign();
        test_invalid();
        test_busy_ignore();
        test_reset_in_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, maximum number of cycles m_req stays asserted without m_ack before the access aborts.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request strobe from the pipeline MEM stage.
REQ-005 addr  input  32  byte address (ALU result).
REQ-006 rt_reg  input  32  store source data.
REQ-007 opcode  input  6  lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
REQ-008 mem_read / mem_write  input  1 each  load / store qualifier.
REQ-009 busy  output  1  pipeline stall; high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 load_data  output  32  formatted load result, valid while done=1, held until the next done.
REQ-012 err  output  1  valid with done; invalid request, timeout, or misalignment.
REQ-013 misaligned  output  1  valid with done; set only for a misalignment trap.
REQ-014 m_req, m_we  output  1 each  memory request and write flag.
REQ-015 m_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-016 m_wdata  output  32  lane-replicated store data.
REQ-017 m_be  output  4  byte enables; m_be[3] = bits 31:24 = byte offset 0 (big-endian).
REQ-018 m_rdata  input  32  read word, sampled in the m_ack cycle.
REQ-019 m_ack  input  1  memory completion; ignored unless m_req=1.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-021 IDLE + start with a valid request (recognized opcode, exactly one of mem_read/mem_write, store opcode iff mem_write) SHALL latch addr, rt_reg and opcode, then go to ACCESS.
REQ-022 IDLE + start with an invalid request SHALL go to DONE with err=1 and never assert m_req.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 In ACCESS, m_req SHALL be 1 and m_we/m_addr/m_wdata/m_be SHALL be stable until m_ack.
REQ-025 ACCESS + m_ack SHALL capture m_rdata and go to DONE with err=0.
REQ-026 A timeout counter SHALL clear on ACCESS entry and increment on each ACCESS cycle without m_ack.
REQ-027 ACCESS with counter = TIMEOUT_CYCLES-1 and no m_ack SHALL go to DONE with err=1; m_ack in that cycle wins.
REQ-028 DONE SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-029 Latency: start at edge N gives m_req in cycle N+1; m_ack in cycle N+k gives done in cycle N+k+1.
REQ-030 Loads SHALL use m_be=0000.
REQ-031 sb: m_be is one-hot by addr[1:0] (00->1000 ... 11->0001), m_wdata = byte replicated x4.
REQ-032 sh: m_be=1100 at offset 0, 0011 at offset 2; m_wdata = halfword replicated x2.
REQ-033 sw: m_be=1111, m_wdata = rt_reg.
REQ-034 lb/lbu SHALL select the byte by offset and sign-/zero-extend it.
REQ-035 lh/lhu SHALL select bits 31:16 at offset 0 or 15:0 at offset 2 and sign-/zero-extend them.
REQ-036 lw SHALL return m_rdata unchanged.
REQ-037 On a timeout or invalid request, load_data SHALL be 0.

Reset
REQ-038 rst_n=0 SHALL immediately force IDLE, counter 0, and all outputs 0 (including load_data), aborting any in-flight access without waiting for m_ack.

Configuration
REQ-039 With LSU_MISALIGN_TRAP_EN defined, an access with addr[0]=1 (half) or addr[1:0]!=00 (word) SHALL go IDLE->DONE without m_req, with err=1 and misaligned=1.
REQ-040 Without LSU_MISALIGN_TRAP_EN, halfword accesses SHALL ignore addr[0], word accesses SHALL ignore addr[1:0], and misaligned SHALL be tied 0.

Verification
REQ-041 sw addr=0x10 rt=0xDEADBEEF, ack one cycle after m_req -> m_addr=0x10, m_be=1111, m_wdata=0xDEADBEEF, done two cycles after start, err=0.
REQ-042 lb addr=0x13, m_rdata=0x1122338F -> load_data=0xFFFFFF8F; lbu same -> 0x0000008F.
REQ-043 lh addr=0x22, m_rdata=0x0000F00D -> load_data=0xFFFFF00D; sh addr=0x22 rt=0x1234ABCD -> m_be=0011, m_wdata=0xABCDABCD.
REQ-044 lw, never ack, TIMEOUT_CYCLES=16 -> m_req high exactly 16 cycles, then done with err=1 and load_data=0.
REQ-045 lw addr=0x41: with macro -> no m_req, done with err=1 and misaligned=1; without macro -> m_addr=0x40, err=0.
REQ-046 rst_n low during ACCESS -> m_req=0 and busy=0 immediately; no done pulse; a later m_ack is ignored.
